// File: rtl/fc_requant_packer.sv
// fc_requant_packer: bias add, optional ReLU, rounding right shift and
// signed saturation of MAC accumulator results, followed by packing of
// PACK signed lanes per output word with a valid/ready handshake.
//
// The whole pipeline advances on one global enable (adv). A stalled output
// word therefore freezes stage 1 and the packer as well, so nothing is lost.
module fc_requant_packer #(
    parameter int IN_BITWIDTH   = 26,
    parameter int BIAS_BITWIDTH = 16,
    parameter int OUT_BITWIDTH  = 8,
    parameter int PACK          = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_BITWIDTH-1:0]         in_data,
    input  logic [BIAS_BITWIDTH-1:0]       in_bias,
    input  logic                           in_last,
    input  logic [4:0]                     cfg_shift,
    input  logic                           cfg_relu,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_BITWIDTH*PACK-1:0]   out_data,
    output logic [PACK-1:0]                out_keep,
    output logic                           out_last
);

    localparam int SW = IN_BITWIDTH + 1;
    localparam int RW = IN_BITWIDTH + 2;
    localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic signed [RW-1:0] QMAX = RW'((1 << (OUT_BITWIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] QMIN = -QMAX - RW'(1);

    logic                          adv;
    logic                          accept;
    logic signed [SW-1:0]          sum_in;
    logic signed [SW-1:0]          s1_sum;
    logic                          s1_valid;
    logic                          s1_last;
    logic signed [RW-1:0]          v;
    logic signed [RW-1:0]          rnd;
    logic signed [RW-1:0]          r;
    logic [5:0]                    sh;
    logic [OUT_BITWIDTH-1:0]       q;
    logic [CW-1:0]                 cnt;
    logic [OUT_BITWIDTH*PACK-1:0]  held;
    logic                          word_done;
    logic                          load;
    logic [OUT_BITWIDTH*PACK-1:0]  word_next;
    logic [PACK-1:0]               keep_next;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // Bias is sign-extended to one bit above the accumulator so the sum cannot overflow.
    assign sum_in = $signed({in_data[IN_BITWIDTH-1], in_data})
                  + $signed({{(SW-BIAS_BITWIDTH){in_bias[BIAS_BITWIDTH-1]}}, in_bias});

    // Stage 1: capture the biased sum on acceptance, drain the valid when advancing empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_sum   <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (accept) begin
            s1_sum   <= sum_in;
            s1_valid <= 1'b1;
            s1_last  <= in_last;
        end else if (adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Requantise stage-1 sum: ReLU, round-half-up shift, saturate to a signed lane.
    always_comb begin
        v   = (cfg_relu && s1_sum[SW-1]) ? '0 : $signed({s1_sum[SW-1], s1_sum});
        sh  = (32'(cfg_shift) > IN_BITWIDTH) ? 6'(IN_BITWIDTH) : {1'b0, cfg_shift};
        rnd = '0;
        if (sh != 6'd0) begin
            rnd = $signed({{(RW-1){1'b0}}, 1'b1} << (sh - 6'd1));
        end
        r = (v + rnd) >>> sh;
        if (r > QMAX) begin
            q = QMAX[OUT_BITWIDTH-1:0];
        end else if (r < QMIN) begin
            q = QMIN[OUT_BITWIDTH-1:0];
        end else begin
            q = r[OUT_BITWIDTH-1:0];
        end
    end

    assign word_done = (cnt == CW'(PACK - 1)) || s1_last;
    assign load      = s1_valid && adv && word_done;

    // Assemble the outgoing word: held lanes below cnt, the new lane at cnt, zeros above.
    always_comb begin
        word_next = '0;
        keep_next = '0;
        for (int i = 0; i < PACK; i++) begin
            if (CW'(i) < cnt) begin
                word_next[i*OUT_BITWIDTH +: OUT_BITWIDTH] = held[i*OUT_BITWIDTH +: OUT_BITWIDTH];
                keep_next[i] = 1'b1;
            end else if (CW'(i) == cnt) begin
                word_next[i*OUT_BITWIDTH +: OUT_BITWIDTH] = q;
                keep_next[i] = 1'b1;
            end
        end
    end

    // Packer: store lanes until the word is full or the layer ends, then restart at lane 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            held <= '0;
        end else if (s1_valid && adv) begin
            if (word_done) begin
                cnt <= '0;
            end else begin
                for (int i = 0; i < PACK - 1; i++) begin
                    if (cnt == CW'(i)) begin
                        held[i*OUT_BITWIDTH +: OUT_BITWIDTH] <= q;
                    end
                end
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Output register: a finished word loads even while the previous one is being taken.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= word_next;
            out_keep  <= keep_next;
            out_last  <= s1_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fc_requant_packer.sv
// Scoreboard bench for fc_requant_packer: the stimulus side pushes
// hand-computed words, a monitor pops and compares on every handshake and
// checks held words during backpressure.
module tb_fc_requant_packer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [25:0] in_data = '0;
    logic [15:0] in_bias = '0;
    logic        in_last = 1'b0;
    logic [4:0]  cfg_shift = '0;
    logic        cfg_relu = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    fc_requant_packer dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bias   (in_bias),
        .in_last   (in_last),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_t e;
        e.data = d;
        e.keep = k;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic send(input int d, input int b, input bit last);
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 26'(d);
        in_bias  = 16'(b);
        in_last  = last;
        #2;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #2;
            guard++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compare on every handshake, and check the held word while stalled.
    always @(negedge clk) begin
        #3;
        if (rstn && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", out_data, 32'hxxxxxxxx);
            end else if (out_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                check("word_data", out_data, e.data);
                check("word_keep", 32'(out_keep), 32'(e.keep));
                check("word_last", 32'(out_last), 32'(e.last));
            end else begin
                check("stall_data", out_data, exp_q[0].data);
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Pack and latency
        push(32'h04030201, 4'b1111, 1'b0);
        send(1, 0, 0);
        send(2, 0, 0);
        send(3, 0, 0);
        send(4, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("lat_t0", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("lat_t1", 32'(out_valid), 32'd1);
        idle(3);

        // Saturation and bias; shift changed only once the pipe is drained
        cfg_shift = 5'd2;
        push(32'h0046807F, 4'b1111, 1'b1);
        send(1000, 0, 0);
        send(-1000, 0, 0);
        idle(3);
        cfg_shift = 5'd0;
        send(100, -30, 0);
        send(0, 0, 1);
        idle(4);

        // Rounding
        cfg_shift = 5'd2;
        push(32'hFEFF0102, 4'b1111, 1'b0);
        send(6, 0, 0);
        send(5, 0, 0);
        send(-6, 0, 0);
        send(-7, 0, 0);
        idle(4);

        // ReLU
        cfg_shift = 5'd0;
        cfg_relu  = 1'b1;
        push(32'h7F320000, 4'b1111, 1'b0);
        send(-50, 0, 0);
        send(-1, 0, 0);
        send(50, 0, 0);
        send(200, 0, 0);
        idle(4);
        cfg_relu = 1'b0;

        // Partial flush, then the next word starts at lane 0
        push(32'h00000A09, 4'b0011, 1'b1);
        send(9, 0, 0);
        send(10, 0, 1);
        push(32'h0E0D0C0B, 4'b1111, 1'b0);
        send(11, 0, 0);
        send(12, 0, 0);
        send(13, 0, 0);
        send(14, 0, 0);
        idle(4);

        // Single-lane flush from an empty packer
        push(32'h00000055, 4'b0001, 1'b1);
        send(85, 0, 1);
        idle(4);

        // Backpressure: stall 5 cycles once the first word shows up
        push(32'h04030201, 4'b1111, 1'b0);
        push(32'h08070605, 4'b1111, 1'b0);
        fork
            begin
                for (int i = 1; i <= 8; i++) send(i, 0, 0);
                idle(1);
            end
            begin
                guard = 0;
                @(negedge clk);
                #1;
                while (!out_valid && guard < 50) begin
                    @(negedge clk);
                    #1;
                    guard++;
                end
                if (!out_valid) check("bp_wait_timeout", 32'(out_valid), 32'd1);
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle(5);

        // Reset mid-word discards the partial word
        send(49, 0, 0);
        send(50, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_out_keep", 32'(out_keep), 32'd0);
        check("mid_rst_out_last", 32'(out_last), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        idle(3);
        check("post_rst_no_word", 32'(out_valid), 32'd0);
        push(32'h18171615, 4'b1111, 1'b0);
        send(21, 0, 0);
        send(22, 0, 0);
        send(23, 0, 0);
        send(24, 0, 0);
        idle(2);

        // Drain
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
